dsram_like_responder: RTL and testbench

Responder (slave) end of the data SRAM-like interface: accepts req/addr handshakes from the CPU-side initiator and returns in-order data_ok/rdata responses. Backed by an internal word-addressed RAM with configurable response latency and outstanding depth. Serves as the behavioural data memory in the core-level testbench and in the FPGA bring-up top. It also serves as the future template for the AXI bridge's data channel.

---
 rtl/dsram_like_responder_pkg.sv | 22 ++
 rtl/dsram_like_responder_if.sv | 27 ++
 rtl/dsram_like_responder_resp_fifo.sv | 70 +++++++
 rtl/dsram_like_responder.sv | 99 +++++++++
 tb/tb_dsram_like_responder.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsram_like_responder_pkg.sv
// Shared types and constants for the data SRAM-like responder: response-queue
// entry layout, access-size codes and the stall LFSR seed/step.
package dsram_pkg;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] data;
        logic [3:0]  age;
    } resp_entry_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/dsram_like_responder_if.sv
// Data SRAM-like bus. Handshake: a request transfers on the cycle req & addr_ok
// are both high; a response transfers every cycle data_ok is high (no back-pressure).
interface dsram_like_responder_if;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

endinterface

// File: rtl/dsram_like_responder_resp_fifo.sv
// In-order response queue: circular buffer with wrapping pointers, an occupancy
// count and a per-entry age counter that saturates at AGE_MAX.
module dsram_resp_fifo
    import dsram_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int AGE_MAX = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  resp_entry_t                  push_entry,
    input  logic                         pop,
    output resp_entry_t                  head,
    output logic                         head_valid,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_entry_t          mem [DEPTH];
    logic [DEPTH-1:0]     valid;
    logic [PW-1:0]        head_ptr;
    logic [PW-1:0]        tail_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            valid    <= '0;
        end else begin
            if (pop) begin
                valid[head_ptr] <= 1'b0;
                head_ptr        <= ptr_next(head_ptr);
            end
            if (push) begin
                valid[tail_ptr] <= 1'b1;
                tail_ptr        <= ptr_next(tail_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; only the valid bits decide what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && tail_ptr == PW'(i)) begin
                mem[i] <= push_entry;
            end else if (valid[i] && mem[i].age < 4'(AGE_MAX)) begin
                mem[i].age <= mem[i].age + 4'd1;
            end
        end
    end

    assign head       = mem[head_ptr];
    assign head_valid = valid[head_ptr];
    assign full       = (count == CW'(DEPTH));

endmodule

// File: rtl/dsram_like_responder.sv
// Behavioural data-SRAM responder: word RAM plus in-order response queue.
// Optional DSRAM_RAND_DELAY_EN adds LFSR-driven accept/response stalls.
module dsram_like_responder
    import dsram_pkg::*;
#(
    parameter int MEM_AW      = 12,
    parameter int OUTSTANDING = 2,
    parameter int DATA_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    dsram_like_responder_if.slave         bus
);

    // Entries are pushed with age 0 and first observable one cycle later,
    // so the stored age lags the true handshake distance by one.
    localparam logic [3:0] READY_AGE = 4'(DATA_LAT - 1);
    localparam int         CW        = $clog2(OUTSTANDING + 1);

    logic [31:0]        mem [2**MEM_AW];
    logic [MEM_AW-1:0]  idx;
    logic               handshake;
    logic               fifo_full;
    logic               head_valid;
    logic               head_ready;
    logic               resp_fire;
    logic               mask_accept;
    logic               hold_head;
    logic [CW-1:0]      fifo_count;
    resp_entry_t        head;
    resp_entry_t        push_entry;
    logic               unused_bits;

`ifdef DSRAM_RAND_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign mask_accept = lfsr[0];
    assign hold_head   = lfsr[1];
`else
    assign mask_accept = 1'b0;
    assign hold_head   = 1'b0;
`endif

    assign idx = bus.data_sram_addr[MEM_AW+1:2];

    assign bus.data_sram_addr_ok = bus.data_sram_req & ~fifo_full & ~mask_accept & ~reset;
    assign handshake             = bus.data_sram_addr_ok;

    assign head_ready            = head_valid & (head.age >= READY_AGE);
    assign resp_fire             = head_ready & ~hold_head & ~reset;
    assign bus.data_sram_data_ok = resp_fire;
    assign bus.data_sram_rdata   = resp_fire ? head.data : 32'h0;

    // Loads capture the word at handshake time, after any earlier store has landed.
    always_comb begin
        push_entry       = '0;
        push_entry.is_wr = bus.data_sram_wr;
        push_entry.data  = bus.data_sram_wr ? 32'h0 : mem[idx];
        push_entry.age   = 4'd0;
    end

    always_ff @(posedge clk) begin
        if (handshake && bus.data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_sram_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    dsram_resp_fifo #(
        .DEPTH   (OUTSTANDING),
        .AGE_MAX (DATA_LAT)
    ) u_resp_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (handshake),
        .push_entry (push_entry),
        .pop        (resp_fire),
        .head       (head),
        .head_valid (head_valid),
        .full       (fifo_full),
        .count      (fifo_count)
    );

    // Size is informational and upper/low address bits alias by design.
    assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[31:MEM_AW+2],
                           bus.data_sram_addr[1:0], fifo_count, head.is_wr};

endmodule

// File: tb/tb_dsram_like_responder.sv
// Bench for dsram_like_responder: two instances (DATA_LAT=1 and DATA_LAT=4),
// a byte-addressed reference memory and in-order response scoreboard.
module tb_dsram_like_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dsram_like_responder_if bus0();
  dsram_like_responder_if bus1();

  logic        drv_sel = 1'b0;
  logic        drv_req = 1'b0;
  logic        drv_wr = 1'b0;
  logic [3:0]  drv_wstrb = 4'h0;
  logic [31:0] drv_addr = 32'h0;
  logic [31:0] drv_wdata = 32'h0;

  assign bus0.data_sram_req   = drv_req & ~drv_sel;
  assign bus0.data_sram_wr    = drv_wr;
  assign bus0.data_sram_size  = 2'd2;
  assign bus0.data_sram_wstrb = drv_wstrb;
  assign bus0.data_sram_addr  = drv_addr;
  assign bus0.data_sram_wdata = drv_wdata;
  assign bus1.data_sram_req   = drv_req & drv_sel;
  assign bus1.data_sram_wr    = drv_wr;
  assign bus1.data_sram_size  = 2'd2;
  assign bus1.data_sram_wstrb = drv_wstrb;
  assign bus1.data_sram_addr  = drv_addr;
  assign bus1.data_sram_wdata = drv_wdata;

  dsram_like_responder #(.MEM_AW(12), .OUTSTANDING(2), .DATA_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  dsram_like_responder #(.MEM_AW(12), .OUTSTANDING(2), .DATA_LAT(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  logic        obs_addr_ok, obs_data_ok;
  logic [31:0] obs_rdata;
  assign obs_addr_ok = drv_sel ? bus1.data_sram_addr_ok : bus0.data_sram_addr_ok;
  assign obs_data_ok = drv_sel ? bus1.data_sram_data_ok : bus0.data_sram_data_ok;
  assign obs_rdata   = drv_sel ? bus1.data_sram_rdata   : bus0.data_sram_rdata;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rdata_leak = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rsp_q[$];
  int          rsp_cyc_q[$];
  int          acc_q[$];
  logic [31:0] ref_mem[int];

  always @(posedge clk) cyc <= cyc + 1;

  // Observation only: log handshakes and responses with their cycle numbers.
  always @(negedge clk) begin
    if (!reset) begin
      if (drv_req && obs_addr_ok) acc_q.push_back(cyc);
      if (obs_data_ok) begin
        rsp_q.push_back(obs_rdata);
        rsp_cyc_q.push_back(cyc);
      end else if (obs_rdata !== 32'h0) begin
        rdata_leak++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    exp_q.delete(); rsp_q.delete(); rsp_cyc_q.delete(); acc_q.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drv_req = 1'b0;
    drv_wr  = 1'b0;
  endtask

  // Drives one request until accepted (bounded) and updates the reference model.
  task automatic issue(input logic wr, input logic [3:0] strb,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int key;
    logic [31:0] w;
    bit got;
    int n;
    key = (drv_sel ? 65536 : 0) + int'((addr >> 2) % 32'd4096);
    drv_req = 1'b1; drv_wr = wr; drv_wstrb = strb; drv_addr = addr; drv_wdata = wdata;
    if (wr) begin
      w = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[key] = w;
      exp_q.push_back(32'h0);
    end else begin
      exp_q.push_back(ref_mem.exists(key) ? ref_mem[key] : 32'h0);
    end
    got = 1'b0;
    n = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      got = obs_addr_ok;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (rsp_q.size() < n && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drv_sel = 1'b0; drv_req = 1'b1; drv_wr = 1'b0; drv_addr = 32'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus0.data_sram_addr_ok, bus0.data_sram_data_ok, bus0.data_sram_rdata} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_dut0: addr_ok=%b data_ok=%b rdata=%h, expected all 0",
               bus0.data_sram_addr_ok, bus0.data_sram_data_ok, bus0.data_sram_rdata);
    end
    drv_sel = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus1.data_sram_addr_ok, bus1.data_sram_data_ok, bus1.data_sram_rdata} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_dut1: addr_ok=%b data_ok=%b rdata=%h, expected all 0",
               bus1.data_sram_addr_ok, bus1.data_sram_data_ok, bus1.data_sram_rdata);
    end
    drv_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drv_sel = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus0.data_sram_data_ok, bus1.data_sram_data_ok} !== 2'b00) begin
      miscompares++;
      $display("FAIL post_reset_data_ok: got %b%b expected 00",
               bus0.data_sram_data_ok, bus1.data_sram_data_ok);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load();
    drv_sel = 1'b0;
    clear_logs();
    issue(1'b1, 4'hF, 32'h100, 32'h1234_5678);
    issue(1'b0, 4'h0, 32'h100, 32'h0);
    idle();
    wait_rsp(2);
    cycles(4);
    vectors++;
    if (rsp_q.size() !== 2) begin
      miscompares++;
      $display("FAIL store_load_count: got %0d responses expected 2", rsp_q.size());
    end
    for (int i = 0; i < rsp_q.size() && i < 2; i++) begin
      vectors++;
      if (rsp_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL store_load_rdata[%0d]: got %h expected %h", i, rsp_q[i], exp_q[i]);
      end
    end
`ifndef DSRAM_RAND_DELAY_EN
    for (int i = 0; i < rsp_cyc_q.size() && i < acc_q.size(); i++) begin
      vectors++;
      if (rsp_cyc_q[i] !== acc_q[i] + 1) begin
        miscompares++;
        $display("FAIL store_load_latency[%0d]: data_ok cycle %0d expected %0d",
                 i, rsp_cyc_q[i], acc_q[i] + 1);
      end
    end
    vectors++;
    if (acc_q.size() !== 2 || acc_q[1] !== acc_q[0] + 1) begin
      miscompares++;
      $display("FAIL store_load_back_to_back: %0d accepts, not on consecutive cycles", acc_q.size());
    end
`endif
  endtask

  task automatic test_byte_store();
    drv_sel = 1'b0;
    clear_logs();
    issue(1'b1, 4'b0010, 32'h101, 32'h0000_AB00);
    issue(1'b0, 4'h0, 32'h100, 32'h0);
    idle();
    wait_rsp(2);
    cycles(3);
    vectors++;
    if (rsp_q.size() !== 2) begin
      miscompares++;
      $display("FAIL byte_store_count: got %0d responses expected 2", rsp_q.size());
    end else begin
      vectors++;
      if (rsp_q[1] !== 32'h1234_AB78 || exp_q[1] !== 32'h1234_AB78) begin
        miscompares++;
        $display("FAIL byte_store_rdata: got %h expected %h", rsp_q[1], 32'h1234_AB78);
      end
    end
  endtask

  task automatic test_full();
    drv_sel = 1'b1;
    clear_logs();
    issue(1'b1, 4'hF, 32'h0, 32'h1111_0000);
    issue(1'b1, 4'hF, 32'h4, 32'h2222_0004);
    issue(1'b1, 4'hF, 32'h8, 32'h3333_0008);
    idle();
    wait_rsp(3);
    cycles(6);
    clear_logs();
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    issue(1'b0, 4'h0, 32'h4, 32'h0);
    issue(1'b0, 4'h0, 32'h8, 32'h0);
    idle();
    wait_rsp(3);
    cycles(6);
    vectors++;
    if (rsp_q.size() !== 3) begin
      miscompares++;
      $display("FAIL full_count: got %0d responses expected 3", rsp_q.size());
    end
    for (int i = 0; i < rsp_q.size() && i < 3; i++) begin
      vectors++;
      if (rsp_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL full_rdata[%0d]: got %h expected %h", i, rsp_q[i], exp_q[i]);
      end
    end
`ifndef DSRAM_RAND_DELAY_EN
    if (acc_q.size() == 3 && rsp_cyc_q.size() == 3) begin
      vectors++;
      if (acc_q[1] !== acc_q[0] + 1) begin
        miscompares++;
        $display("FAIL full_second_accept: cycle %0d expected %0d", acc_q[1], acc_q[0] + 1);
      end
      vectors++;
      if (acc_q[2] !== rsp_cyc_q[0] + 1) begin
        miscompares++;
        $display("FAIL full_third_accept: cycle %0d expected %0d", acc_q[2], rsp_cyc_q[0] + 1);
      end
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (rsp_cyc_q[i] !== acc_q[i] + 4) begin
          miscompares++;
          $display("FAIL full_latency[%0d]: data_ok cycle %0d expected %0d",
                   i, rsp_cyc_q[i], acc_q[i] + 4);
        end
      end
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL full_log: got %0d accepts / %0d responses expected 3/3",
               acc_q.size(), rsp_cyc_q.size());
    end
`endif
  endtask

  task automatic test_reset_mid();
    drv_sel = 1'b1;
    clear_logs();
    issue(1'b1, 4'hF, 32'h100, 32'hCAFE_F00D);
    idle();
    wait_rsp(1);
    cycles(2);
    clear_logs();
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    issue(1'b0, 4'h0, 32'h14, 32'h0);
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycles(12);
    vectors++;
    if (rsp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_discard: got %0d responses after reset expected 0", rsp_q.size());
    end
    clear_logs();
    issue(1'b0, 4'h0, 32'h100, 32'h0);
    idle();
    wait_rsp(1);
    cycles(2);
    vectors++;
    if (rsp_q.size() !== 1 || rsp_q[0] !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL reset_mid_ram_kept: got %0d responses first=%h expected 1 x %h",
               rsp_q.size(), rsp_q.size() > 0 ? rsp_q[0] : 32'h0, 32'hCAFE_F00D);
    end
  endtask

  task automatic test_alias();
    drv_sel = 1'b0;
    clear_logs();
    issue(1'b1, 4'hF, 32'h4000, 32'hDEAD_BEEF);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    idle();
    wait_rsp(2);
    cycles(3);
    vectors++;
    if (rsp_q.size() !== 2 || rsp_q[1] !== 32'hDEAD_BEEF || exp_q[1] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL alias_rdata: got %0d responses last=%h expected 2, last %h",
               rsp_q.size(), rsp_q.size() > 1 ? rsp_q[1] : 32'h0, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_random(input logic sel, input int n_ops, input int lat);
    logic [31:0] addr;
    int errs = 0;
    drv_sel = sel;
    clear_logs();
    for (int k = 0; k < 16; k++) issue(1'b1, 4'hF, 32'h200 + 32'(k * 4), $urandom);
    for (int i = 0; i < n_ops; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        cycles($urandom_range(1, 2));
      end
      addr = (32'($urandom_range(0, 7)) << 14) | 32'h200 |
             (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), addr, $urandom);
    end
    idle();
    wait_rsp(exp_q.size());
    cycles(8);
    vectors++;
    if (rsp_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL random_count_sel%0d: got %0d responses expected %0d",
               sel, rsp_q.size(), exp_q.size());
    end
    for (int i = 0; i < rsp_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (rsp_q[i] !== exp_q[i]) begin
        miscompares++;
        errs++;
        if (errs < 10)
          $display("FAIL random_rdata_sel%0d[%0d]: got %h expected %h", sel, i, rsp_q[i], exp_q[i]);
      end
    end
`ifndef DSRAM_RAND_DELAY_EN
    for (int i = 0; i < rsp_cyc_q.size() && i < acc_q.size(); i++) begin
      vectors++;
      if (rsp_cyc_q[i] !== acc_q[i] + lat) begin
        miscompares++;
        errs++;
        if (errs < 10)
          $display("FAIL random_latency_sel%0d[%0d]: data_ok cycle %0d expected %0d",
                   sel, i, rsp_cyc_q[i], acc_q[i] + lat);
      end
    end
`endif
  endtask

  task automatic test_idle_rdata();
    vectors++;
    if (rdata_leak !== 0) begin
      miscompares++;
      $display("FAIL idle_rdata: %0d cycles with nonzero rdata while data_ok=0, expected 0", rdata_leak);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_store();
    test_full();
    test_reset_mid();
    test_alias();
    test_random(1'b0, 1000, 1);
    test_random(1'b1, 200, 4);
    test_idle_rdata();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
